divider: RTL and testbench



---
 rtl/divider_pkg.sv | 20 ++
 rtl/divider.sv | 121 ++++++++++++
 tb/tb_divider.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and helpers for the sequential signed fixed-point divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Bits needed to count 0..n-1 (minimum 1).
  function automatic int clog2(input int unsigned n);
    int r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = int'(i) + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/divider.sv
// Sequential signed fixed-point divider: out = trunc((a <<< IN_SCALE) / b),
// wrapped to OUT_WIDTH bits. One quotient bit per cycle, restoring division
// on magnitudes with the sign applied on the final edge.
// Ports:
//   clk, arst            clock, asynchronous active-high reset
//   a, b, in_valid       operands and request; accepted when in_ready=1
//   in_ready             divider idle
//   out, div_by_zero     result and zero-divisor flag, qualified by out_valid
//   out_valid, out_ready result handshake
module divider
  import divider_pkg::*;
#(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 8,
  parameter int OUT_WIDTH = 16,
  parameter int IN_SCALE  = 8
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] out,
  output logic                        div_by_zero,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int N  = A_WIDTH + IN_SCALE;
  localparam int CW = clog2(N);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [N-1:0]         dvd;
  logic [N-1:0]         quo;
  logic [B_WIDTH-1:0]   div_mag;
  logic [B_WIDTH-1:0]   rem;
  logic                 neg;
  logic                 zero;

  logic [A_WIDTH-1:0]   a_mag;
  logic [B_WIDTH-1:0]   b_mag;
  logic [B_WIDTH:0]     rem_sh;
  logic                 ge;
  logic [B_WIDTH-1:0]   rem_next;
  logic [N-1:0]         quo_next;
  logic [N-1:0]         quo_fix;

  always_comb begin
    // Magnitudes are unsigned, so the most negative operand is representable.
    a_mag    = a[A_WIDTH-1] ? (~a + 1'b1) : a;
    b_mag    = b[B_WIDTH-1] ? (~b + 1'b1) : b;
    rem_sh   = {rem, dvd[N-1]};
    ge       = rem_sh >= {1'b0, div_mag};
    // Remainder stays below |b|, so it always fits back into B_WIDTH bits.
    rem_next = B_WIDTH'(ge ? (rem_sh - {1'b0, div_mag}) : rem_sh);
    quo_next = {quo[N-2:0], ge};
    quo_fix  = neg ? (~quo_next + 1'b1) : quo_next;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd         <= '0;
      quo         <= '0;
      div_mag     <= '0;
      rem         <= '0;
      neg         <= 1'b0;
      zero        <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= BUSY;
            in_ready <= 1'b0;
            cnt      <= '0;
            dvd      <= N'(a_mag) << IN_SCALE;
            div_mag  <= b_mag;
            rem      <= '0;
            quo      <= '0;
            neg      <= a[A_WIDTH-1] ^ b[B_WIDTH-1];
            zero     <= (b == '0);
          end
        end
        BUSY: begin
          dvd <= dvd << 1;
          rem <= rem_next;
          quo <= quo_next;
          if (cnt == CW'(N - 1)) begin
            state       <= DONE;
            cnt         <= '0;
            out_valid   <= 1'b1;
            out         <= zero ? '0 : OUT_WIDTH'(quo_fix);
            div_by_zero <= zero;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed vector table, backpressure and
// reset sequences, then randomized transactions against an arithmetic model.
module tb_divider;

  localparam int AW = 16;
  localparam int BW = 8;
  localparam int OW = 16;
  localparam int SC = 8;
  localparam int NLAT = AW + SC;

  logic                 clk = 1'b0;
  logic                 arst;
  logic signed [AW-1:0] a;
  logic signed [BW-1:0] b;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [OW-1:0] out;
  logic                 div_by_zero;
  logic                 out_valid;
  logic                 out_ready;

  int checks   = 0;
  int failures = 0;

  divider #(
    .A_WIDTH  (AW),
    .B_WIDTH  (BW),
    .OUT_WIDTH(OW),
    .IN_SCALE (SC)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .a          (a),
    .b          (b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out        (out),
    .div_by_zero(div_by_zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic signed [AW-1:0] a;
    logic signed [BW-1:0] b;
    logic [OW-1:0]        exp_out;
    logic                 exp_dbz;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: scaled dividend over divisor, truncated toward zero, wrapped.
  function automatic logic [OW-1:0] ref_div(input int ra, input int rb);
    longint num;
    longint q;
    logic [63:0] qb;
    if (rb == 0) return '0;
    num = longint'(ra) * (longint'(1) << SC);
    q   = num / longint'(rb);
    qb  = q;
    return qb[OW-1:0];
  endfunction

  // mode 0: out_ready held 1; mode 1: random out_ready; mode 2: 5-cycle stall
  // with a competing in_valid, then release.
  task automatic run_one(input logic signed [AW-1:0] ta, input logic signed [BW-1:0] tb,
                         input int mode, output logic [OW-1:0] got,
                         output logic gdz, output int lat);
    int   guard;
    logic busy_ok;
    logic hold_ok;
    logic took;
    guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    if (!in_ready) chk("idle_wait", {31'd0, in_ready}, 32'd1);
    a         = ta;
    b         = tb;
    in_valid  = 1'b1;
    out_ready = (mode == 0);
    step();
    in_valid = 1'b0;
    a        = AW'($urandom);
    b        = BW'($urandom);
    lat      = 0;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready) busy_ok = 1'b0;
      step();
      lat++;
    end
    if (in_ready) busy_ok = 1'b0;
    chk("busy_in_ready_low", {31'd0, busy_ok}, 32'd1);
    got     = out;
    gdz     = div_by_zero;
    hold_ok = 1'b1;
    if (mode == 0) begin
      step();
    end else if (mode == 1) begin
      took  = 1'b0;
      guard = 0;
      while (!took) begin
        out_ready = (guard > 20) ? 1'b1 : 1'($urandom_range(0, 1));
        took      = out_ready;
        step();
        guard++;
        if (!took && (out !== got || div_by_zero !== gdz || !out_valid || in_ready))
          hold_ok = 1'b0;
      end
    end else begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      a         = 16'sd77;
      b         = 8'sd7;
      for (int unsigned i = 0; i < 5; i++) begin
        step();
        if (out !== got || div_by_zero !== gdz || !out_valid || in_ready) hold_ok = 1'b0;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    if (mode != 0) chk("hold_stable", {31'd0, hold_ok}, 32'd1);
    chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vec_t        vecs[8];
    logic [OW-1:0] got;
    logic        gdz;
    int          lat;
    logic        pulse;
    int          ra;
    int          rb;

    vecs[0] = '{16'sd100,    8'sd4,    16'h1900, 1'b0};
    vecs[1] = '{-16'sd100,   8'sd3,    16'hDEAB, 1'b0};
    vecs[2] = '{16'sd100,    -8'sd3,   16'hDEAB, 1'b0};
    vecs[3] = '{-16'sd100,   -8'sd3,   16'h2155, 1'b0};
    vecs[4] = '{16'sd32767,  8'sd1,    16'hFF00, 1'b0};
    vecs[5] = '{-16'sd32768, -8'sd128, 16'h0000, 1'b0};
    vecs[6] = '{16'sd55,     8'sd0,    16'h0000, 1'b1};
    vecs[7] = '{16'sd8,      8'sd2,    16'h0400, 1'b0};

    arst      = 1'b1;
    a         = '0;
    b         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", {16'd0, out}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    step();
    step();
    arst = 1'b0;
    step();

    for (int unsigned i = 0; i < 8; i++) begin
      run_one(vecs[i].a, vecs[i].b, 0, got, gdz, lat);
      chk($sformatf("vec%0d_out", i), {16'd0, got}, {16'd0, vecs[i].exp_out});
      chk($sformatf("vec%0d_dbz", i), {31'd0, gdz}, {31'd0, vecs[i].exp_dbz});
      chk($sformatf("vec%0d_latency", i), lat, NLAT);
    end

    // Backpressure: 5-cycle stall with a competing request that must be ignored.
    run_one(16'sd300, 8'sd5, 2, got, gdz, lat);
    chk("bp_out", {16'd0, got}, {16'd0, ref_div(300, 5)});
    step();
    chk("bp_still_idle", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of the iteration phase.
    a        = 16'sd1234;
    b        = 8'sd5;
    in_valid = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 10; i++) step();
    arst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out", {16'd0, out}, 32'd0);
    step();
    arst  = 1'b0;
    pulse = 1'b0;
    for (int unsigned i = 0; i < 30; i++) begin
      step();
      if (out_valid) pulse = 1'b1;
    end
    out_ready = 1'b0;
    chk("midrst_no_pulse", {31'd0, pulse}, 32'd0);
    run_one(16'sd1, 8'sd1, 0, got, gdz, lat);
    chk("after_rst_out", {16'd0, got}, 32'd256);
    chk("after_rst_latency", lat, NLAT);

    // Randomized transactions with random output backpressure.
    for (int unsigned t = 0; t < 2000; t++) begin
      ra = int'($urandom_range(0, 65535)) - 32768;
      case ($urandom_range(0, 15))
        0:       rb = 0;
        1:       rb = -128;
        2:       rb = (($urandom_range(0, 1) == 1) ? 1 : -1);
        default: rb = int'($urandom_range(0, 255)) - 128;
      endcase
      if ($urandom_range(0, 15) == 0) ra = (($urandom_range(0, 1) == 1) ? 32767 : -32768);
      run_one(AW'(ra), BW'(rb), 1, got, gdz, lat);
      chk("rand_out", {16'd0, got}, {16'd0, ref_div(ra, rb)});
      chk("rand_dbz", {31'd0, gdz}, {31'd0, (rb == 0)});
      chk("rand_latency", lat, NLAT);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
